// File: rtl/tff_bank_sync_reset.sv
// Bank of WIDTH toggle flip-flops with a stretched synchronous reset, parallel load
// and an optional saturating toggle-event counter (enable with `define TFF_BANK_CNT_EN).
module tff_bank_sync_reset #(
  parameter int WIDTH      = 8,
  parameter int RST_STAGES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic             any_tgl,
  output logic [CNT_W-1:0] tgl_cnt,
  output logic             rst_busy
);

  localparam logic [RST_STAGES-1:0] PIPE_ONE = RST_STAGES'(1);

  logic [RST_STAGES-1:0] rst_pipe;
  logic                  int_rst;

  // Release stretcher: ones walk in from bit 0 once reset goes high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) rst_pipe <= '0;
    else        rst_pipe <= (rst_pipe << 1) | PIPE_ONE;
  end

  assign int_rst = !reset || !rst_pipe[RST_STAGES-1];

  // Load beats toggle; internal reset beats both.
  always_ff @(posedge clk) begin
    rst_busy <= int_rst;
    if (int_rst) begin
      q       <= '0;
      any_tgl <= 1'b0;
    end else if (load) begin
      q       <= load_val;
      any_tgl <= 1'b0;
    end else begin
      q       <= q ^ data;
      any_tgl <= |data;
    end
  end

`ifdef TFF_BANK_CNT_EN
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  logic [CNT_W-1:0] inc;
  logic [CNT_W-1:0] base;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_next;

  // Clear zeroes the base, so same-cycle toggles still land in the count.
  // NOTE: always_comb assigns every output unconditionally, so no latch can form.
  always_comb begin
    inc      = load ? '0 : popcount(data);
    base     = clr_cnt ? '0 : tgl_cnt;
    sum      = {1'b0, base} + {1'b0, inc};
    cnt_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (int_rst) tgl_cnt <= '0;
    else         tgl_cnt <= cnt_next;
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign tgl_cnt        = '0;
`endif

endmodule

// File: tb/tb_tff_bank_sync_reset.sv
// Directed self-checking bench for tff_bank_sync_reset (WIDTH=8, RST_STAGES=2, CNT_W=4).
module tb_tff_bank_sync_reset;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       load;
  logic [7:0] load_val;
  logic       clr_cnt;
  logic [7:0] q;
  logic       any_tgl;
  logic [3:0] tgl_cnt;
  logic       rst_busy;

  int n_tests = 0;
  int n_fail  = 0;

  tff_bank_sync_reset #(.WIDTH(8), .RST_STAGES(2), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .load     (load),
    .load_val (load_val),
    .clr_cnt  (clr_cnt),
    .q        (q),
    .any_tgl  (any_tgl),
    .tgl_cnt  (tgl_cnt),
    .rst_busy (rst_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  // Counter value expected in this build; the counter is tied to 0 when disabled.
  function automatic logic [3:0] ec(input logic [3:0] v);
`ifdef TFF_BANK_CNT_EN
    return v;
`else
    return 4'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [7:0] eq, input logic ea,
                            input logic [3:0] ecnt, input logic eb);
    check({tag, ".q"},        q,               eq);
    check({tag, ".any_tgl"},  {7'd0, any_tgl}, {7'd0, ea});
    check({tag, ".tgl_cnt"},  {4'd0, tgl_cnt}, {4'd0, ec(ecnt)});
    check({tag, ".rst_busy"}, {7'd0, rst_busy}, {7'd0, eb});
  endtask

  initial begin
    reset = 1'b0; data = 8'h00; load = 1'b0; load_val = 8'h00; clr_cnt = 1'b0;

    // Reset held low for 3 edges.
    tick(); tick(); tick();
    expect_all("reset", 8'h00, 1'b0, 4'd0, 1'b1);

    // Release with data=FF: two stretched edges, then toggling; count saturates at 15.
    reset = 1'b1; data = 8'hFF;
    tick(); expect_all("rel_k",   8'h00, 1'b0, 4'd0,  1'b1);
    tick(); expect_all("rel_k1",  8'h00, 1'b0, 4'd0,  1'b1);
    tick(); expect_all("rel_k2",  8'hFF, 1'b1, 4'd8,  1'b0);
    tick(); expect_all("sat_16",  8'h00, 1'b1, 4'd15, 1'b0);
    data = 8'h01;
    tick(); expect_all("sat_hold", 8'h01, 1'b1, 4'd15, 1'b0);

    // Clear with no toggles, then load 00 while data is ignored.
    clr_cnt = 1'b1; data = 8'h00;
    tick(); expect_all("clr_idle", 8'h01, 1'b0, 4'd0, 1'b0);
    clr_cnt = 1'b0; load = 1'b1; load_val = 8'h00; data = 8'hFF;
    tick(); expect_all("load_00", 8'h00, 1'b0, 4'd0, 1'b0);
    load = 1'b0;

    // data=05 for 4 cycles.
    data = 8'h05;
    tick(); expect_all("tgl_1", 8'h05, 1'b1, 4'd2, 1'b0);
    tick(); expect_all("tgl_2", 8'h00, 1'b1, 4'd4, 1'b0);
    tick(); expect_all("tgl_3", 8'h05, 1'b1, 4'd6, 1'b0);
    tick(); expect_all("tgl_4", 8'h00, 1'b1, 4'd8, 1'b0);

    // Load priority over simultaneous data.
    load = 1'b1; load_val = 8'h0F; data = 8'h00;
    tick(); expect_all("load_0f", 8'h0F, 1'b0, 4'd8, 1'b0);
    load_val = 8'hA5; data = 8'hFF;
    tick(); expect_all("load_a5", 8'hA5, 1'b0, 4'd8, 1'b0);
    load = 1'b0; data = 8'h01;
    tick(); expect_all("cnt_9",   8'hA4, 1'b1, 4'd9, 1'b0);

    // Clear with a same-cycle toggle keeps that cycle's toggles.
    clr_cnt = 1'b1; data = 8'h03;
    tick(); expect_all("clr_tgl", 8'hA7, 1'b1, 4'd2, 1'b0);
    clr_cnt = 1'b0;

    // Build up to 12, then a 1-cycle reset pulse with toggles and clear in flight.
    data = 8'hFF;
    tick(); expect_all("mid_10", 8'h58, 1'b1, 4'd10, 1'b0);
    data = 8'h03;
    tick(); expect_all("mid_12", 8'h5B, 1'b1, 4'd12, 1'b0);
    reset = 1'b0; data = 8'hFF; clr_cnt = 1'b1;
    tick(); expect_all("mid_rst", 8'h00, 1'b0, 4'd0, 1'b1);
    reset = 1'b1; clr_cnt = 1'b0;
    tick(); expect_all("mid_k",  8'h00, 1'b0, 4'd0, 1'b1);
    tick(); expect_all("mid_k1", 8'h00, 1'b0, 4'd0, 1'b1);
    tick(); expect_all("mid_k2", 8'hFF, 1'b1, 4'd8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_bank_sync_reset.md
# tff_bank_sync_reset

Parametrised bank of WIDTH toggle flip-flops sharing one clock and one synchronous active-low reset, with a built-in reset-release stretcher, parallel load, and an optional saturating toggle-event counter. It generalises the single-bit T flip-flop into a multi-channel register. It sits wherever the design needs per-bit toggle state, such as phase flags or divide-by-2 lanes, with a clean, stretched reset.

## Interface
Parameters:
- WIDTH, 8, number of toggle channels (≥1)
- RST_STAGES, 2, reset-release stretch depth in cycles (≥1)
- CNT_W, 16, toggle-event counter width (≥ clog2(WIDTH+1))

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- data  input  WIDTH  per-channel toggle enable; bit i = 1 toggles q[i]
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value written to q when load = 1
- clr_cnt  input  1  synchronous counter clear
- q  output  WIDTH  toggle state, registered
- any_tgl  output  1  registered; 1 when the last update toggled ≥1 bit
- tgl_cnt  output  CNT_W  saturating count of toggled bits
- rst_busy  output  1  registered; 1 while internal reset is active

## Operation
- Reset pipe: a shift register rst_pipe[RST_STAGES-1:0].
  - When reset = 0, all stages are cleared to 0.
  - Otherwise the pipe shifts in 1 each cycle.
- Internal reset int_rst = (reset == 0) | (rst_pipe[RST_STAGES-1] == 0).
- Per-edge priority, highest first:
  1. int_rst: q ← 0, any_tgl ← 0, tgl_cnt ← 0, rst_busy ← 1.
  2. load: q ← load_val, any_tgl ← 0. data is ignored and nothing is counted.
  3. Toggle: q ← q ^ data, any_tgl ← |data.
- Counter update, when not in int_rst:
  - inc = popcount(data) when toggling, else 0. inc is 0 when load = 1.
  - clr_cnt = 1: tgl_cnt ← inc. The clear is applied first, so toggles in the same cycle are still counted.
  - Otherwise tgl_cnt ← min(tgl_cnt + inc, 2^CNT_W − 1). The sum is computed at CNT_W+1 bits, then saturated. There is no wrap.
- rst_busy ← int_rst, evaluated every edge.
- Reset values: q = 0, any_tgl = 0, tgl_cnt = 0, rst_busy = 1, rst_pipe = 0.

## Timing
- Reset assertion:
  - Takes effect at the first edge that samples reset = 0; outputs are 0 after that edge.
  - A 1-cycle low pulse is sufficient.
- Reset release: after the first edge sampling reset = 1, int_rst stays active for RST_STAGES more edges.
  - With RST_STAGES = 2, first edge sampling reset = 1 is edge k: q/tgl_cnt are held at 0 through edge k+1. The first toggle is accepted at edge k+2.
  - rst_busy falls after edge k+2.
- Reset mid-operation: in-flight toggles and loads on that edge are discarded. The counter is cleared even if saturated.
- Latency: data/load → q is 1 cycle, and any_tgl/tgl_cnt update on the same edge.
- Back-to-back data = 1 on channel i gives a q[i] square wave at clk/2.
- Simultaneous load and data: load wins, and the count is unaffected.
- Simultaneous clr_cnt and int_rst: reset wins.
- No handshake: every non-reset edge is consumed.

## Configuration
- TFF_BANK_CNT_EN defined: the counter and its popcount/saturation logic are compiled in, as described above.
- Not defined:
  - tgl_cnt is tied to 0 and clr_cnt is ignored.
  - q, any_tgl and rst_busy behave identically, and no counter flops are inferred.

## Test plan
- Reset stretch: WIDTH = 8, RST_STAGES = 2, reset low 3 cycles then high, data = 8'hFF every cycle.
  - q stays 8'h00 and rst_busy stays 1 for 2 edges after release.
  - Then q alternates 8'hFF / 8'h00, and rst_busy falls with the first toggle.
- Toggle/count: data = 8'b0000_0101 for 4 cycles.
  - q goes 05, 00, 05, 00; any_tgl = 1 each cycle; tgl_cnt = 8 (with TFF_BANK_CNT_EN).
- Load priority: q = 8'h0F, then load = 1, load_val = 8'hA5, data = 8'hFF in the same cycle.
  - q = 8'hA5, any_tgl = 0, tgl_cnt unchanged.
- Saturation: CNT_W = 4, data = 8'hFF for 2 cycles.
  - tgl_cnt = 8, then 15 (saturated, not 0).
  - A further data = 8'h01 keeps it at 15.
- Clear with toggle: tgl_cnt = 9, then clr_cnt = 1 with data = 8'h03.
  - tgl_cnt = 2 next cycle, and q bits 0 and 1 invert.
- Mid-run reset: toggling with data = 8'hFF, tgl_cnt = 12, reset low for 1 cycle.
  - On that edge q = 0, tgl_cnt = 0, any_tgl = 0.
  - Toggling resumes RST_STAGES edges after reset returns high.
